// File: rtl/mem_ctrl.sv
//------------------------------------------------------------------------------
// Module      : mem_ctrl
// Description : Serialises word-wide MEM-stage accesses onto a byte-wide
//               synchronous RAM port and assembles read words.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_ctrl #(
    parameter int RAM_AW = 17
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       mem_addr,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [3:0]        mem_mask,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_data,
    output logic              busy,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        RTAIL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [1:0]          r_cnt;
    logic [RAM_AW-1:0]   r_addr;
    logic                r_write;
    logic [3:0]          r_mask;
    logic [31:0]         r_wdata;
    logic [23:0]         r_word;

    logic                w_req;
    logic [1:0]          w_cnt_nxt;
    logic [RAM_AW-1:0]   w_addr_nxt;
    logic [31:0]         w_wshift;
    logic                w_unused_addr;

    assign w_req         = mem_read | mem_write;
    assign w_cnt_nxt     = r_cnt + 2'd1;
    assign w_addr_nxt    = r_addr + {{(RAM_AW-2){1'b0}}, w_cnt_nxt};
    assign w_wshift      = r_wdata >> {w_cnt_nxt, 3'b000};
    assign w_unused_addr = ^mem_addr[31:RAM_AW];

    // Low during DONE so the pipeline advances exactly once per access.
    assign busy = w_req & (r_state != DONE) & ~RST;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next_state = XFER;
                end
            end
            XFER: begin
                if (r_cnt == 2'd3) begin
                    w_next_state = r_write ? DONE : RTAIL;
                end
            end
            RTAIL: w_next_state = DONE;
            DONE:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // RAM-side outputs are registered one byte ahead: the edge leaving
    // IDLE already presents byte 0, each XFER edge presents the next byte.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt    <= 2'd0;
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_mask   <= 4'd0;
            r_wdata  <= 32'd0;
            r_word   <= 24'd0;
            ram_addr <= '0;
            ram_wr   <= 1'b0;
            ram_din  <= 8'd0;
            mem_data <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    ram_wr <= 1'b0;
                    if (w_req) begin
                        r_cnt    <= 2'd0;
                        r_addr   <= mem_addr[RAM_AW-1:0];
                        r_write  <= mem_write;
                        r_mask   <= mem_mask;
                        r_wdata  <= mem_wdata;
                        ram_addr <= mem_addr[RAM_AW-1:0];
                        ram_wr   <= mem_write & mem_mask[0];
                        ram_din  <= mem_wdata[7:0];
                    end
                end
                XFER: begin
                    r_cnt <= w_cnt_nxt;
                    if (r_cnt != 2'd3) begin
                        ram_addr <= w_addr_nxt;
                        ram_wr   <= r_write & r_mask[w_cnt_nxt];
                        ram_din  <= w_wshift[7:0];
                    end else begin
                        ram_wr <= 1'b0;
                    end
                    // RAM read data trails its address by one cycle.
                    if (!r_write) begin
                        case (r_cnt)
                            2'd1:    r_word[7:0]   <= ram_dout;
                            2'd2:    r_word[15:8]  <= ram_dout;
                            2'd3:    r_word[23:16] <= ram_dout;
                            default: r_word        <= r_word;
                        endcase
                    end
                end
                RTAIL: begin
                    ram_wr   <= 1'b0;
                    mem_data <= {ram_dout, r_word};
                end
                DONE: begin
                    ram_wr <= 1'b0;
                end
                default: begin
                    ram_wr <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller directly downstream of the MEM stage.
- Accepts the word-aligned access the MEM stage issues (address, read/write strobes, byte mask, write data). Serialises it onto a byte-wide synchronous RAM port.
- Returns the assembled read word and a busy flag. The MEM stage turns busy into its pipeline stall request.

Parameters:
RAM_AW, 17, byte-address width of the external RAM port; ram_addr = lower RAM_AW bits of (word address + byte index).

Ports:
CLK  in  1  system clock; all state updates on rising edge
RST  in  1  asynchronous, active-high reset
mem_addr  in  32  word-aligned byte address from MEM stage (bits [1:0] are 00)
mem_read  in  1  read request
mem_write  in  1  write request
mem_mask  in  4  byte-write enables, bit i = byte lane i (bits [8i+7:8i])
mem_wdata  in  32  write data, already lane-aligned
mem_data  out  32  assembled read word, little-endian
busy  out  1  access in progress; MEM stage must hold inputs and stall
ram_addr  out  RAM_AW  byte address to RAM
ram_wr  out  1  byte write strobe
ram_din  out  8  byte write data to RAM
ram_dout  in  8  byte read data from RAM, valid one cycle after ram_addr

Behaviour:
- Reset (async, RST=1):
  - state=IDLE, cnt=0.
  - Registers ram_addr=0, ram_wr=0, ram_din=0, mem_data=0.
  - busy=0 while RST is high.
- Request = mem_read | mem_write. If both are set, the write wins and the read is ignored.
- busy is combinational: busy = request & (state != DONE), forced 0 in reset.
  - busy rises in the same cycle a request appears in IDLE.
  - busy falls in the DONE cycle, which lets the pipeline advance.
- States: IDLE, XFER, RTAIL, DONE.
- IDLE, with a request (cycle 0):
  - Latch addr, op, mask and wdata internally. Later input changes are ignored until IDLE.
  - Set cnt=0 and go to XFER.
  - With no request, stay in IDLE and drive ram_wr=0.
- XFER (cycles 1..4, cnt=0..3):
  - Registered outputs present ram_addr = latched_addr + cnt.
  - Write: ram_din = wdata byte cnt; ram_wr = mask[cnt], so unmasked bytes get no write pulse.
  - Read: ram_wr=0.
  - cnt increments each cycle.
  - After cnt=3: a write goes to DONE; a read goes to RTAIL.
- Read capture:
  - Byte k is returned on ram_dout in the cycle after its address, i.e. cycle k+2.
  - It is captured into the internal word lane k on the following edge.
  - RTAIL (cycle 5) captures byte 3. The completed word is then copied to mem_data and the block goes to DONE.
- DONE (one cycle):
  - Read: cycle 6. Write: cycle 5.
  - busy=0, ram_wr=0, mem_data valid.
  - Always go to IDLE next, even if a request is still present. The next request is sampled only in the following cycle, which prevents re-executing the instruction just completed.
- Latency:
  - Read: busy high for 6 cycles, mem_data valid in cycle 6.
  - Write: busy high for 5 cycles.
  - Minimum request spacing is one DONE plus one IDLE cycle.
- mem_data holds its value until the next read completes; writes do not alter it.
- mask=0000 write: still takes 4 XFER cycles with no ram_wr pulses, then DONE.
- Address wrap: latched_addr + cnt is truncated to RAM_AW bits, so the top word wraps to byte address 0.
- Reset mid-operation: the access is abandoned immediately, ram_wr=0, partial bytes already written remain written, the read word is discarded, and the block returns to IDLE.

Test Plan:
- Reset then idle (mem_read=mem_write=0) -> busy=0, ram_wr=0, mem_data=0 indefinitely.
- SW addr 0x100, mask 1111, wdata 0xDEADBEEF:
  - RAM bytes 0x100..0x103 = EF,BE,AD,DE.
  - busy high for 5 cycles; 4 ram_wr pulses.
- SB-style write addr 0x104, mask 0100, wdata 0x00AA0000 -> exactly one ram_wr at ram_addr 0x106 with ram_din=0xAA; other bytes unchanged.
- Read addr 0x100 after the SW above -> mem_data=0xDEADBEEF in cycle 6; busy low only in that cycle; IDLE one cycle before the next access.
- Back-to-back identical reads held across DONE -> exactly two RAM read sequences, with one IDLE gap between them.
- RST asserted in XFER cnt=2 of a write -> busy, ram_wr drop asynchronously; bytes 0,1 written, bytes 2,3 untouched; next request starts from IDLE normally.
